// File: rtl/fma_add_pipe.sv
// fma_add_pipe: three-stage pipelined IEEE-754 adder (align / add / normalise-round)
// for any binary format with NE exponent bits and NF fraction bits.
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready = pipeline advance
//   p, z, rm          product and addend operands, rounding mode (0 RNE, 1 RZ)
//   out_valid/ready   result handshake; consumer may stall the whole pipe
//   sum, flags        rounded result and {invalid, overflow, inexact}
// Subnormal operands and results flush to zero. NaN/inf/zero cases are resolved
// in stage 1 and travel to the output as a bypass value.
module fma_add_pipe #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [NE+NF:0] p,
  input  logic [NE+NF:0] z,
  input  logic         rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [NE+NF:0] sum,
  output logic [2:0]   flags
);
  localparam int W      = 1 + NE + NF;
  localparam int SW     = NF + 4;             // hidden, fraction, guard, round, sticky
  localparam int MW     = NF + 5;             // SW plus carry-out
  localparam int EW     = NE + $clog2(MW) + 2; // two's-complement working exponent
  localparam int STAGES = 3;

  localparam logic [NE-1:0] EXP_ONES = {NE{1'b1}};
  localparam logic [NE-1:0] EXP_MAXF = {{(NE-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(NF-1){1'b0}}};
  localparam logic [EW-1:0] EXP_OVF  = EW'((1 << NE) - 1);

  logic              advance;
  logic [STAGES:1]   vldPipe;

  assign advance   = ~vldPipe[STAGES] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vldPipe[STAGES];

  // ---------------- stage 1: classify, swap, align ----------------
  logic          pSign, zSign;
  logic [NE-1:0] pExp, zExp;
  logic [NF-1:0] pFrac, zFrac;
  assign {pSign, pExp, pFrac} = p;
  assign {zSign, zExp, zFrac} = z;

  logic pZero, zZero, pInf, zInf, pNan, zNan, pSnan, zSnan;
  // exp == 0 covers both true zero and flushed subnormals
  assign pZero = (pExp == '0);
  assign zZero = (zExp == '0);
  assign pInf  = (pExp == EXP_ONES) && (pFrac == '0);
  assign zInf  = (zExp == EXP_ONES) && (zFrac == '0);
  assign pNan  = (pExp == EXP_ONES) && (pFrac != '0);
  assign zNan  = (zExp == EXP_ONES) && (zFrac != '0);
  assign pSnan = pNan && !pFrac[NF-1];
  assign zSnan = zNan && !zFrac[NF-1];

  logic         byp;
  logic [W-1:0] bypVal;
  logic [2:0]   bypFlags;
  always_comb begin
    byp      = 1'b1;
    bypVal   = '0;
    bypFlags = '0;
    if (pNan || zNan) begin
      bypVal   = QNAN;
      bypFlags = {pSnan | zSnan, 2'b00};
    end else if (pInf && zInf) begin
      if (pSign != zSign) begin
        bypVal   = QNAN;
        bypFlags = 3'b100;
      end else begin
        bypVal = p;
      end
    end else if (pInf) begin
      bypVal = p;
    end else if (zInf) begin
      bypVal = z;
    end else if (pZero && zZero) begin
      bypVal = {pSign & zSign, {(W-1){1'b0}}};
    end else if (pZero) begin
      bypVal = z;
    end else if (zZero) begin
      bypVal = p;
    end else begin
      byp = 1'b0;
    end
  end

  logic          pBig, lSign, sSign;
  logic [NE-1:0] lExp, sExp, dExp;
  logic [NF-1:0] lFrac, sFrac;
  logic [SW-1:0] sigL, sigS0, sigSh, lostMask, sigS;

  assign pBig = (p[W-2:0] >= z[W-2:0]);
  assign {lSign, lExp, lFrac} = pBig ? p : z;
  assign {sSign, sExp, sFrac} = pBig ? z : p;
  assign dExp     = lExp - sExp;
  assign sigL     = {1'b1, lFrac, 3'b000};
  assign sigS0    = {1'b1, sFrac, 3'b000};
  assign sigSh    = sigS0 >> dExp;
  assign lostMask = ~({SW{1'b1}} << dExp);

  always_comb begin
    if (int'(dExp) >= SW - 1)
      sigS = {{(SW-1){1'b0}}, 1'b1};
    else
      sigS = {sigSh[SW-1:1], sigSh[0] | (|(sigS0 & lostMask))};
  end

  logic          s1Byp, s1Rm, s1Sign, s1Sub;
  logic [W-1:0]  s1BypVal;
  logic [2:0]    s1BypFlags;
  logic [NE-1:0] s1Exp;
  logic [SW-1:0] s1SigL, s1SigS;

  // ---------------- stage 2: magnitude add/subtract ----------------
  // The swap guarantees L >= S, so the difference never goes negative.
  logic [MW-1:0] magSum;
  assign magSum = s1Sub ? ({1'b0, s1SigL} - {1'b0, s1SigS})
                        : ({1'b0, s1SigL} + {1'b0, s1SigS});

  logic          s2Byp, s2Rm, s2Sign;
  logic [W-1:0]  s2BypVal;
  logic [2:0]    s2BypFlags;
  logic [NE-1:0] s2Exp;
  logic [MW-1:0] s2Mag;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [EW-1:0] lzc;
  always_comb begin
    lzc = '0;
    // highest set bit wins because it is visited last
    for (int i = 0; i < SW; i++)
      if (s2Mag[i]) lzc = EW'(SW - 1 - i);
  end

  logic [EW-1:0] expIn, expN, expR;
  logic [SW-1:0] norm;
  always_comb begin
    expIn = {{(EW-NE){1'b0}}, s2Exp};
    if (s2Mag[MW-1]) begin
      norm = {s2Mag[MW-1:2], s2Mag[1] | s2Mag[0]};
      expN = expIn + EW'(1);
    end else begin
      norm = s2Mag[SW-1:0] << lzc;
      expN = expIn - lzc;
    end
  end

  logic          lsb, g, r, st, inc, rndCarry, inexact, underflow, overflow;
  logic [NF:0]   rnd;
  assign {lsb, g, r, st} = norm[3:0];
  assign inc       = ~s2Rm & g & (r | st | lsb);
  // A wrap of the NF+1-bit significand clears the hidden bit: that is the carry.
  assign rnd       = norm[SW-1:3] + {{NF{1'b0}}, inc};
  assign rndCarry  = ~rnd[NF];
  assign expR      = rndCarry ? expN + EW'(1) : expN;
  assign inexact   = g | r | st;
  assign underflow = expN[EW-1] | (expN == '0);
  assign overflow  = ~expR[EW-1] & (expR >= EXP_OVF);

  logic [W-1:0] res;
  logic [2:0]   resFlags;
  always_comb begin
    res      = {s2Sign, expR[NE-1:0], rnd[NF-1:0]};
    resFlags = {2'b00, inexact};
    if (s2Byp) begin
      res      = s2BypVal;
      resFlags = s2BypFlags;
    end else if (s2Mag == '0) begin
      res      = '0;
      resFlags = '0;
    end else if (underflow) begin
      res      = '0;
      resFlags = 3'b001;
    end else if (overflow) begin
      res      = s2Rm ? {s2Sign, EXP_MAXF, {NF{1'b1}}} : {s2Sign, EXP_ONES, {NF{1'b0}}};
      resFlags = 3'b011;
    end
  end

  // ---------------- pipeline registers ----------------
  // Every stage moves together on advance; bubbles shift like real ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vldPipe    <= '0;
      s1Byp      <= 1'b0;
      s1Rm       <= 1'b0;
      s1Sign     <= 1'b0;
      s1Sub      <= 1'b0;
      s1BypVal   <= '0;
      s1BypFlags <= '0;
      s1Exp      <= '0;
      s1SigL     <= '0;
      s1SigS     <= '0;
      s2Byp      <= 1'b0;
      s2Rm       <= 1'b0;
      s2Sign     <= 1'b0;
      s2BypVal   <= '0;
      s2BypFlags <= '0;
      s2Exp      <= '0;
      s2Mag      <= '0;
      sum        <= '0;
      flags      <= '0;
    end else if (advance) begin
      vldPipe    <= {vldPipe[STAGES-1:1], in_valid};
      s1Byp      <= byp;
      s1Rm       <= rm;
      s1Sign     <= lSign;
      s1Sub      <= lSign ^ sSign;
      s1BypVal   <= bypVal;
      s1BypFlags <= bypFlags;
      s1Exp      <= lExp;
      s1SigL     <= sigL;
      s1SigS     <= sigS;
      s2Byp      <= s1Byp;
      s2Rm       <= s1Rm;
      s2Sign     <= s1Sign;
      s2BypVal   <= s1BypVal;
      s2BypFlags <= s1BypFlags;
      s2Exp      <= s1Exp;
      s2Mag      <= magSum;
      sum        <= res;
      flags      <= resFlags;
    end
  end

endmodule
